// File: rtl/aes_keyslot_ctrl.sv
// Register front-end and start/done sequencer for a block-cipher engine with write-only key slots.
// Sequential key zeroization is built only when AES_KEYSLOT_ZEROIZE_EN is defined.
module aes_keyslot_ctrl #(
  parameter int NUM_KEYS = 3,
  parameter int BLOCK_W  = 128,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               eng_start_o,
  output logic [BLOCK_W-1:0] eng_key_o,
  output logic [BLOCK_W-1:0] eng_pt_o,
  output logic [BLOCK_W-1:0] eng_iv_o,
  input  logic               eng_done_i,
  input  logic [BLOCK_W-1:0] eng_ct_i
);
  localparam int NW = BLOCK_W / 32;
  localparam int TW = $clog2(TIMEOUT + 1);

  // state  | meaning
  // S_IDLE | accepting configuration and start requests
  // S_BUSY | engine running, key/PT/IV frozen, timeout counting down
  // S_ZERO | clearing one key slot per cycle (zeroize build only)
`ifdef AES_KEYSLOT_ZEROIZE_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ZERO} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_BUSY} state_e;
`endif

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] pt_q, pt_d, iv_q, iv_d, ct_q, ct_d;
  logic [BLOCK_W-1:0] keys_q [NUM_KEYS];
  logic [BLOCK_W-1:0] keys_d [NUM_KEYS];
  logic [2:0]         key_sel_q, key_sel_d, cur_sel_q, cur_sel_d, lock_q, lock_d;
  logic               err_q, err_d, ct_valid_q, ct_valid_d, start_q, start_d;
  logic [TW-1:0]      timer_q, timer_d;
`ifdef AES_KEYSLOT_ZEROIZE_EN
  logic [2:0]         zcnt_q, zcnt_d;
`endif

  logic [5:0]  widx;
  logic [1:0]  woff;
  logic        wr, idle, word_ok, key_hit, zero_st;
  logic [31:0] wd, rd_word;
  logic [BLOCK_W-1:0] key_mux;
  logic        unused_bits;

  assign widx    = addr_i[8:3];
  assign woff    = widx[1:0];
  assign wd      = wdata_i[31:0];
  assign wr      = en_i & we_i;
  assign idle    = (state_q == S_IDLE);
  assign word_ok = (int'(woff) < NW);
  assign key_hit = widx[5] && (int'(widx[4:2]) < NUM_KEYS);
  assign unused_bits = ^{addr_i[ADDR_W-1:9], addr_i[2:0], wdata_i[DATA_W-1:32]};
`ifdef AES_KEYSLOT_ZEROIZE_EN
  assign zero_st = (state_q == S_ZERO);
`else
  assign zero_st = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pt_d       = pt_q;
    iv_d       = iv_q;
    ct_d       = ct_q;
    keys_d     = keys_q;
    key_sel_d  = key_sel_q;
    cur_sel_d  = cur_sel_q;
    lock_d     = lock_q;
    err_d      = err_q;
    ct_valid_d = ct_valid_q;
    timer_d    = timer_q;
    start_d    = 1'b0;
`ifdef AES_KEYSLOT_ZEROIZE_EN
    zcnt_d     = zcnt_q;
`endif
    if (wr) begin
      if (widx == 6'd0 && wd[0]) begin
        if (idle && int'(key_sel_q) < NUM_KEYS) begin
          state_d    = S_BUSY;
          start_d    = 1'b1;
          ct_valid_d = 1'b0;
          cur_sel_d  = key_sel_q;
          timer_d    = TW'(TIMEOUT - 1);
        end else begin
          err_d = 1'b1;
        end
      end
      if (widx == 6'd1 && wd[2]) err_d = 1'b0;
      if (widx == 6'd2) begin
        if (!idle) err_d = 1'b1;
        else if (!lock_q[2]) key_sel_d = wd[2:0];
      end
      if (widx == 6'd3) lock_d = lock_q | wd[2:0];
`ifdef AES_KEYSLOT_ZEROIZE_EN
      if (widx == 6'd4 && wd[0]) begin
        if (idle) begin
          state_d = S_ZERO;
          zcnt_d  = 3'd0;
        end else begin
          err_d = 1'b1;
        end
      end
`endif
      if (widx[5:3] == 3'b001) begin
        if (!idle) err_d = 1'b1;
        else if (!lock_q[1] && word_ok) begin
          if (widx[2]) iv_d[32*int'(woff) +: 32] = wd;
          else         pt_d[32*int'(woff) +: 32] = wd;
        end
      end
      if (key_hit) begin
        if (!idle) err_d = 1'b1;
        else if (!lock_q[0] && word_ok) begin
          for (int k = 0; k < NUM_KEYS; k++)
            if (widx[4:2] == 3'(k)) keys_d[k][32*int'(woff) +: 32] = wd;
        end
      end
    end

    case (state_q)
      S_BUSY: begin
        // done has priority over an expiring timer in the same cycle
        if (eng_done_i) begin
          ct_d       = eng_ct_i;
          ct_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (timer_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef AES_KEYSLOT_ZEROIZE_EN
      S_ZERO: begin
        for (int k = 0; k < NUM_KEYS; k++)
          if (zcnt_q == 3'(k)) keys_d[k] = '0;
        if (int'(zcnt_q) == NUM_KEYS - 1) begin
          ct_d       = '0;
          ct_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          zcnt_d = zcnt_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pt_q       <= '0;
      iv_q       <= '0;
      ct_q       <= '0;
      for (int k = 0; k < NUM_KEYS; k++) keys_q[k] <= '0;
      key_sel_q  <= '0;
      cur_sel_q  <= '0;
      lock_q     <= '0;
      err_q      <= 1'b0;
      ct_valid_q <= 1'b0;
      timer_q    <= '0;
      start_q    <= 1'b0;
`ifdef AES_KEYSLOT_ZEROIZE_EN
      zcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pt_q       <= pt_d;
      iv_q       <= iv_d;
      ct_q       <= ct_d;
      keys_q     <= keys_d;
      key_sel_q  <= key_sel_d;
      cur_sel_q  <= cur_sel_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      ct_valid_q <= ct_valid_d;
      timer_q    <= timer_d;
      start_q    <= start_d;
`ifdef AES_KEYSLOT_ZEROIZE_EN
      zcnt_q     <= zcnt_d;
`endif
    end
  end

  // Key slots are deliberately absent from the read path.
  always_comb begin
    rd_word = '0;
    if (en_i && !we_i) begin
      if (widx == 6'd1)      rd_word = {28'd0, zero_st, err_q, ct_valid_q, state_q == S_BUSY};
      else if (widx == 6'd2) rd_word = {29'd0, key_sel_q};
      else if (widx == 6'd3) rd_word = {29'd0, lock_q};
      else if (widx[5:2] == 4'd2 && word_ok) rd_word = pt_q[32*int'(woff) +: 32];
      else if (widx[5:2] == 4'd3 && word_ok) rd_word = iv_q[32*int'(woff) +: 32];
      else if (widx[5:2] == 4'd4 && word_ok) rd_word = ct_q[32*int'(woff) +: 32];
    end
  end

  always_comb begin
    key_mux = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (cur_sel_q == 3'(k)) key_mux = keys_q[k];
  end

  assign rdata_o     = DATA_W'(rd_word);
  assign eng_start_o = start_q;
  assign eng_key_o   = key_mux;
  assign eng_pt_o    = pt_q;
  assign eng_iv_o    = iv_q;

endmodule

// File: tb/tb_aes_keyslot_ctrl.sv
// Directed/randomized bench for aes_keyslot_ctrl against a transaction-level register model.
module tb_aes_keyslot_ctrl;
  localparam int NK = 3;
  localparam int BW = 128;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 1024;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i, rdata_o;
  logic          eng_start_o, eng_done_i;
  logic [BW-1:0] eng_key_o, eng_pt_o, eng_iv_o, eng_ct_i;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] m_key [NK];
  logic [BW-1:0] m_pt, m_iv, m_ct;
  logic [2:0]    m_sel, m_lock;
  bit            m_busy, m_zero, m_ctv, m_err;

  aes_keyslot_ctrl #(.NUM_KEYS(NK), .BLOCK_W(BW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .eng_start_o(eng_start_o), .eng_key_o(eng_key_o),
    .eng_pt_o(eng_pt_o), .eng_iv_o(eng_iv_o), .eng_done_i(eng_done_i), .eng_ct_i(eng_ct_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) m_key[k] = '0;
    m_pt = '0; m_iv = '0; m_ct = '0;
    m_sel = '0; m_lock = '0;
    m_busy = 0; m_zero = 0; m_ctv = 0; m_err = 0;
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d);
    bit idle;
    idle = !m_busy && !m_zero;
    if (w == 0) begin
      if (d[0]) begin
        if (idle && int'(m_sel) < NK) begin m_busy = 1; m_ctv = 0; end
        else m_err = 1;
      end
    end
    else if (w == 1) begin if (d[2]) m_err = 0; end
    else if (w == 2) begin
      if (!idle) m_err = 1;
      else if (!m_lock[2]) m_sel = d[2:0];
    end
    else if (w == 3) m_lock = m_lock | d[2:0];
`ifdef AES_KEYSLOT_ZEROIZE_EN
    else if (w == 4) begin
      if (d[0]) begin
        if (idle) m_zero = 1;
        else m_err = 1;
      end
    end
`endif
    else if (w >= 8 && w <= 15) begin
      if (!idle) m_err = 1;
      else if (!m_lock[1]) begin
        if (w < 12) m_pt[32*(w-8) +: 32] = d;
        else        m_iv[32*(w-12) +: 32] = d;
      end
    end
    else if (w >= 32 && w < 32 + 4*NK) begin
      if (!idle) m_err = 1;
      else if (!m_lock[0]) m_key[(w-32)/4][32*(w%4) +: 32] = d;
    end
  endfunction

  function automatic logic [31:0] m_read(input int w);
    if (w == 1) return {28'd0, m_zero, m_err, m_ctv, m_busy};
    if (w == 2) return {29'd0, m_sel};
    if (w == 3) return {29'd0, m_lock};
    if (w >= 8 && w <= 11) return m_pt[32*(w-8) +: 32];
    if (w >= 12 && w <= 15) return m_iv[32*(w-12) +: 32];
    if (w >= 16 && w <= 19) return m_ct[32*(w-16) +: 32];
    return 32'd0;
  endfunction

  task automatic bus_write(input int w, input logic [31:0] d);
    @(negedge clk_i);
    en_i = 1'b1; we_i = 1'b1;
    addr_i = (AW'(w) << 3) | AW'($urandom_range(0, 7));
    wdata_i = {$urandom, d};
    #1;
    check("rd_during_write", 128'(rdata_o), '0);
    @(posedge clk_i); #1;
    en_i = 1'b0; we_i = 1'b0;
    model_write(w, d);
  endtask

  task automatic bus_read(input int w, output logic [DW-1:0] v);
    @(negedge clk_i);
    en_i = 1'b1; we_i = 1'b0;
    addr_i = (AW'(w) << 3) | AW'($urandom_range(0, 7));
    #1;
    v = rdata_o;
    @(posedge clk_i); #1;
    en_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int w);
    logic [DW-1:0] v;
    bus_read(w, v);
    check(tag, 128'(v), 128'(m_read(w)));
  endtask

  task automatic wr_block(input int base, input logic [127:0] val);
    for (int i = 0; i < 4; i++) bus_write(base + i, val[32*i +: 32]);
  endtask

  task automatic rd_block(input string tag, input int base);
    for (int i = 0; i < 4; i++) rd_chk(tag, base + i);
  endtask

  // Start with the current KEY_SEL, answer with done after lat cycles of busy.
  task automatic run_op(input logic [127:0] ct, input int lat);
    logic [BW-1:0] exp_key;
    int  starts;
    bit  held;
    exp_key = m_key[int'(m_sel)];
    bus_write(0, 32'd1);
    check("start_pulse", 128'(eng_start_o), 128'd1);
    check("eng_key", eng_key_o, exp_key);
    check("eng_pt", eng_pt_o, m_pt);
    check("eng_iv", eng_iv_o, m_iv);
    starts = 0; held = 1;
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin eng_done_i = 1'b1; eng_ct_i = ct; end
      @(posedge clk_i); #1;
      eng_done_i = 1'b0;
      if (i < lat) begin
        if (eng_start_o !== 1'b0) starts++;
        if (eng_key_o !== exp_key) held = 0;
      end
    end
    check("start_single", 128'(starts), '0);
    check("key_held", 128'(held), 128'd1);
    m_busy = 0; m_ct = ct; m_ctv = 1;
    rd_chk("op_status", 1);
    rd_block("op_ct", 16);
  endtask

  // Start and watch busy; optionally return done in busy cycle done_at.
  task automatic run_timeout(input int done_at, input logic [127:0] ct);
    int cnt;
    bus_write(0, 32'd1);
    en_i = 1'b1; we_i = 1'b0; addr_i = AW'(1) << 3;
    cnt = 0;
    for (int c = 0; c < TO + 10; c++) begin
      #1;
      if (rdata_o[0] !== 1'b1) break;
      cnt++;
      if (cnt == done_at) begin eng_done_i = 1'b1; eng_ct_i = ct; end
      @(posedge clk_i); #1;
      eng_done_i = 1'b0;
    end
    en_i = 1'b0;
    check("busy_cycles", 128'(cnt), 128'(TO));
    m_busy = 0;
    if (done_at == TO) begin m_ct = ct; m_ctv = 1; end
    else m_err = 1;
  endtask

  initial begin
    logic [BW-1:0] r, ct_a5, key1;
    int  sel;
    bit  ok;
    rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    eng_done_i = 1'b0; eng_ct_i = '0;
    model_reset();
    #12;
    check("rst_start", 128'(eng_start_o), '0);
    check("rst_key", eng_key_o, '0);
    check("rst_pt", eng_pt_o, '0);
    check("rst_iv", eng_iv_o, '0);
    check("rdata_no_en", 128'(rdata_o), '0);
    @(negedge clk_i); rst_i = 1'b0;
    rd_chk("rst_status", 1);
    rd_chk("rst_lock", 3);
    rd_chk("rst_ct0", 16);

    key1 = 128'h000102030405060708090A0B0C0D0E0F;
    ct_a5 = {4{32'hA5A5A5A5}};
    wr_block(32, rnd128());
    wr_block(36, key1);
    wr_block(40, rnd128());
    for (int w = 32; w < 32 + 4*NK; w++) rd_chk("key_reads_zero", w);
    rd_chk("undef_5", 5);
    rd_chk("undef_20", 20);
    rd_chk("ctrl_reads_zero", 0);
    rd_chk("zeroize_reads_zero", 4);
    wr_block(8, rnd128());
    wr_block(12, rnd128());
    rd_block("pt_rb", 8);
    rd_block("iv_rb", 12);
    bus_write(2, 32'd1);
    rd_chk("keysel_rb", 2);
    run_op(ct_a5, 12);

    for (int it = 0; it < 4; it++) begin
      sel = $urandom_range(0, NK - 1);
      bus_write(32 + 4*sel + $urandom_range(0, 3), $urandom);
      bus_write(8 + $urandom_range(0, 7), $urandom);
      bus_write(2, 32'(sel));
      run_op(rnd128(), $urandom_range(1, 30));
    end

    bus_write(16, $urandom);
    rd_chk("ct_ro", 16);

    bus_write(2, 32'd0);
    r = m_key[0];
    bus_write(0, 32'd1);
    bus_write(9, $urandom);
    bus_write(0, 32'd1);
    bus_write(33, $urandom);
    bus_write(2, 32'd2);
    check("busy_key_frozen", eng_key_o, r);
    eng_done_i = 1'b1; eng_ct_i = rnd128();
    r = eng_ct_i;
    @(posedge clk_i); #1;
    eng_done_i = 1'b0;
    m_busy = 0; m_ct = r; m_ctv = 1;
    rd_chk("busy_wr_status", 1);
    rd_block("busy_pt_kept", 8);
    rd_chk("busy_sel_kept", 2);
    eng_done_i = 1'b1; eng_ct_i = rnd128();
    @(posedge clk_i); #1;
    eng_done_i = 1'b0;
    rd_chk("idle_done_ct", 17);
    bus_write(1, 32'd4);
    rd_chk("err_clear", 1);

    bus_write(2, 32'($urandom_range(NK, 7)));
    rd_chk("badsel_rb", 2);
    bus_write(0, 32'd1);
    ok = (eng_start_o === 1'b0);
    @(posedge clk_i); #1;
    ok = ok && (eng_start_o === 1'b0);
    check("badsel_nostart", 128'(ok), 128'd1);
    rd_chk("badsel_status", 1);
    bus_write(1, 32'd4);
    rd_chk("badsel_clear", 1);

    bus_write(2, 32'($urandom_range(0, NK - 1)));
    r = rnd128();
    run_timeout(TO, r);
    rd_chk("coincide_status", 1);
    rd_block("coincide_ct", 16);
    run_timeout(0, '0);
    rd_chk("timeout_status", 1);
    eng_done_i = 1'b1; eng_ct_i = rnd128();
    @(posedge clk_i); #1;
    eng_done_i = 1'b0;
    rd_chk("late_done_status", 1);
    rd_block("late_done_ct", 16);
    bus_write(1, 32'd4);

    bus_write(2, 32'd1);
    bus_write(0, 32'd1);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_key", eng_key_o, '0);
    check("midrst_pt", eng_pt_o, '0);
    check("midrst_start", 128'(eng_start_o), '0);
    model_reset();
    @(negedge clk_i); rst_i = 1'b0;
    eng_done_i = 1'b1; eng_ct_i = rnd128();
    @(posedge clk_i); #1;
    eng_done_i = 1'b0;
    rd_chk("midrst_status", 1);
    rd_block("midrst_ct", 16);

`ifdef AES_KEYSLOT_ZEROIZE_EN
    for (int k = 0; k < NK; k++) wr_block(32 + 4*k, rnd128());
    bus_write(2, 32'd2);
    run_op(rnd128(), 5);
    bus_write(4, 32'd1);
    rd_chk("zero_cyc1", 1);
    bus_write(0, 32'd1);
    rd_chk("zero_cyc3", 1);
    m_zero = 0; m_ct = '0; m_ctv = 0;
    for (int k = 0; k < NK; k++) m_key[k] = '0;
    rd_chk("zero_end", 1);
    rd_block("zero_ct", 16);
    bus_write(1, 32'd4);
    for (int k = 0; k < NK; k++) begin
      bus_write(2, 32'(k));
      run_op(rnd128(), 3);
    end
`else
    bus_write(4, 32'd1);
    rd_chk("nozero_status", 1);
    rd_chk("nozero_rd", 4);
`endif

    bus_write(3, 32'd1);
    rd_chk("lock_set", 3);
    wr_block(32, rnd128());
    bus_write(2, 32'd0);
    run_op(rnd128(), 4);
    bus_write(3, 32'd0);
    rd_chk("lock_sticky", 3);
    bus_write(3, 32'd2);
    wr_block(8, rnd128());
    rd_block("lock_pt", 8);
    bus_write(3, 32'd4);
    bus_write(2, 32'd1);
    rd_chk("lock_sel", 2);
    rd_chk("lock_status", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
